pm_bank_mem: RTL and testbench
==============================

// Module: pm_bank_mem
// PURPOSE
//  Double-buffered path-metric store for the Viterbi ACS-to-traceback path. Collects one
//  trellis step (one metric + decision bit per state, any order) in a collect bank; on commit
//  swaps it into a present bank read by traceback/ACS feedback. Tracks per-step minimum metric
//  and its state, and applies MSB renormalisation so metrics never overflow PM_W bits.
// PARAMETERS
//  PM_W    7  path-metric width (bits)
//  ADDR_W  2  state-address width; NUM_ST = 2**ADDR_W states
//  ID_W    3  data/frame id width
//  NORM_EN 1  1 = MSB renormalisation enabled, 0 = metrics passed unmodified
// PORTS
//  PM_clk      in   1       clock, all logic on rising edge
//  PM_rst      in   1       asynchronous, active-high reset
//  wr_en       in   1       write strobe, accepted when wr_en && wr_ready
//  wr_addr     in   ADDR_W  state index of write
//  wr_pm       in   PM_W    path metric of state
//  wr_dec      in   1       survivor decision bit of state
//  wr_id       in   ID_W    data id of step, sampled on commit write
//  wr_last     in   1       with accepted write: last write of step -> commit
//  wr_ready    out  1       write side may proceed
//  rd_en       in   1       read request for present bank
//  rd_addr     in   ADDR_W  state index to read
//  rd_release  in   1       consumer done with present bank
//  step_rdy    out  1       present bank valid
//  step_id     out  ID_W    id of present step
//  min_pm      out  PM_W    minimum metric of present step (normalised)
//  min_addr    out  ADDR_W  state holding min_pm
//  rd_vld      out  1       rd_pm/rd_dec valid this cycle
//  rd_pm       out  PM_W    metric read (normalised)
//  rd_dec      out  1       decision bit read
//  step_err    out  1       1-cycle pulse: committed step missing or duplicate writes
// BEHAVIOUR
//  - Reset: all outputs 0 except wr_ready=1; mask, dup flag, bank select, norm flag cleared.
//  - Banks: mem[2][NUM_ST] of {pm,dec}; sel names collect bank, !sel present bank.
//  - wr_ready = !step_rdy || rd_release (combinational; release and commit may coincide).
//  - Accepted write: mem[sel][wr_addr] <= {wr_pm,wr_dec}; mask[wr_addr] set; if already set,
//    dup flag set. Running min updated: take new if wr_pm<min, or equal with wr_addr<min_addr.
//    First write of step loads min unconditionally. Writes with wr_ready=0 are ignored entirely.
//  - Commit (accepted write with wr_last): includes that write; next cycle sel toggles,
//    step_rdy=1, step_id=wr_id, min_pm/min_addr latched, norm=NORM_EN && min[PM_W-1];
//    mask, dup, running min cleared. step_err pulses if mask incl. last write != all-ones or dup.
//  - rd_release with step_rdy and no commit: step_rdy->0 next cycle. With commit: stays 1, new data.
//  - Normalisation: if norm, every value read from present bank (rd_pm, min_pm) has MSB cleared
//    (== subtract 2**(PM_W-1); valid since all metrics >= min). Stored data never modified.
//  - Read: rd_en && step_rdy -> next cycle rd_vld=1, rd_pm/rd_dec from present bank as of request
//    cycle. Read in commit cycle returns old present bank. rd_en && !step_rdy -> rd_vld=0, rd_pm/
//    rd_dec hold. rd_vld is a 1-cycle pulse per request; back-to-back reads give 1/cycle.
//  - Latency: commit write -> step_rdy 1 cycle; rd_en -> rd_vld 1 cycle.
//  - Reset mid-step: partial step discarded, no step_err, both banks invalid.
// TESTING
//  1 Reset, write states 0..3 pm={9,4,7,4} dec={1,0,1,1}, last on addr3, id=5 -> next cycle
//    step_rdy=1, step_id=5, min_pm=4, min_addr=1, step_err=0; read addr2 -> rd_pm=7, rd_dec=1.
//  2 Step with pm={70,66,80,127} -> norm: min_pm=2, min_addr=1, read addr3 -> rd_pm=63;
//    NORM_EN=0 build -> min_pm=66, rd_pm=127.
//  3 step_rdy=1, no release, second step written to end -> wr_ready=0, last write ignored, present
//    data unchanged; assert rd_release with last write -> commit, step_rdy stays 1, new id.
//  4 Commit after writing addr 0,1,1,3 -> step_err pulse 1 cycle, step_rdy=1, addr1 = last value.
//  5 rd_en on commit cycle -> rd_pm from old step; rd_en next cycle -> new step value.
//  6 PM_rst asserted after 2 of 4 writes -> all outputs 0, wr_ready=1; fresh full step commits clean.

Source files
------------

// File: rtl/pm_bank_if.sv
// pm_bank_if: write, read and status bundle of the double-buffered path-metric store
interface pm_bank_if #(
    parameter int PM_W   = 7,
    parameter int ADDR_W = 2,
    parameter int ID_W   = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PM_W-1:0]   wr_pm;
    logic              wr_dec;
    logic [ID_W-1:0]   wr_id;
    logic              wr_last;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_release;
    logic              step_rdy;
    logic [ID_W-1:0]   step_id;
    logic [PM_W-1:0]   min_pm;
    logic [ADDR_W-1:0] min_addr;
    logic              rd_vld;
    logic [PM_W-1:0]   rd_pm;
    logic              rd_dec;
    logic              step_err;
    modport master (
        output wr_en, wr_addr, wr_pm, wr_dec, wr_id, wr_last, rd_en, rd_addr, rd_release,
        input  wr_ready, step_rdy, step_id, min_pm, min_addr, rd_vld, rd_pm, rd_dec, step_err
    );
    modport slave (
        input  wr_en, wr_addr, wr_pm, wr_dec, wr_id, wr_last, rd_en, rd_addr, rd_release,
        output wr_ready, step_rdy, step_id, min_pm, min_addr, rd_vld, rd_pm, rd_dec, step_err
    );
endinterface

// File: rtl/pm_bank_mem.sv
// pm_bank_mem: double-buffered Viterbi path-metric bank with per-step minimum and MSB renormalisation
module pm_bank_mem #(
    parameter int PM_W    = 7,
    parameter int ADDR_W  = 2,
    parameter int ID_W    = 3,
    parameter bit NORM_EN = 1'b1
) (
    input logic     PM_clk,
    input logic     PM_rst,
    pm_bank_if.slave b
);
    localparam int NUM_ST = 2**ADDR_W;
    localparam logic [PM_W-1:0] LOW = {1'b0, {(PM_W-1){1'b1}}};

    logic [PM_W:0]       mem_q [2][NUM_ST];
    logic                sel_q, dup_q, dup_d, rdy_q, rdy_d, norm_q, norm_d;
    logic                err_q, err_d, rv_q, rv_d, rdec_q, rdec_d;
    logic [NUM_ST-1:0]   mask_q, mask_d, mask_w;
    logic [PM_W-1:0]     rmin_q, rmin_d, pmin_q, pmin_d, rpm_q, rpm_d, rd_raw, cmin;
    logic [ADDR_W-1:0]   raddr_q, raddr_d, paddr_q, paddr_d, caddr;
    logic [ID_W-1:0]     id_q, id_d;
    logic                acc, com, take, dup_w;

    always_comb begin
        acc     = b.wr_en && b.wr_ready;
        com     = acc && b.wr_last;
        mask_w  = mask_q | (NUM_ST'(1) << b.wr_addr);
        dup_w   = dup_q | mask_q[b.wr_addr];
        take    = mask_q == '0 || b.wr_pm < rmin_q || (b.wr_pm == rmin_q && b.wr_addr < raddr_q);
        cmin    = take ? b.wr_pm : rmin_q;
        caddr   = take ? b.wr_addr : raddr_q;
        rd_raw  = mem_q[!sel_q][b.rd_addr][PM_W:1];
        mask_d  = com ? '0 : acc ? mask_w : mask_q;
        dup_d   = com ? 1'b0 : acc ? dup_w : dup_q;
        rmin_d  = com ? '0 : acc ? cmin : rmin_q;
        raddr_d = com ? '0 : acc ? caddr : raddr_q;
        rdy_d   = com || (rdy_q && !b.rd_release);
        id_d    = com ? b.wr_id : id_q;
        pmin_d  = com ? cmin : pmin_q;
        paddr_d = com ? caddr : paddr_q;
        norm_d  = com ? (NORM_EN && cmin[PM_W-1]) : norm_q;
        err_d   = com && (mask_w != '1 || dup_w);
        rv_d    = b.rd_en && rdy_q;
        // reads are normalised with the flag of the bank they were taken from
        rpm_d   = rv_d ? (norm_q ? rd_raw & LOW : rd_raw) : rpm_q;
        rdec_d  = rv_d ? mem_q[!sel_q][b.rd_addr][0] : rdec_q;
    end

    always_ff @(posedge PM_clk) begin
        if (acc) mem_q[sel_q][b.wr_addr] <= {b.wr_pm, b.wr_dec};
    end

    always_ff @(posedge PM_clk or posedge PM_rst) begin
        if (PM_rst) begin
            sel_q   <= 1'b0;
            mask_q  <= '0;
            dup_q   <= 1'b0;
            rmin_q  <= '0;
            raddr_q <= '0;
            rdy_q   <= 1'b0;
            id_q    <= '0;
            pmin_q  <= '0;
            paddr_q <= '0;
            norm_q  <= 1'b0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
            rpm_q   <= '0;
            rdec_q  <= 1'b0;
        end else begin
            sel_q   <= sel_q ^ com;
            mask_q  <= mask_d;
            dup_q   <= dup_d;
            rmin_q  <= rmin_d;
            raddr_q <= raddr_d;
            rdy_q   <= rdy_d;
            id_q    <= id_d;
            pmin_q  <= pmin_d;
            paddr_q <= paddr_d;
            norm_q  <= norm_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
            rpm_q   <= rpm_d;
            rdec_q  <= rdec_d;
        end
    end

    assign b.wr_ready = !rdy_q || b.rd_release;
    assign b.step_rdy = rdy_q;
    assign b.step_id  = id_q;
    assign b.min_pm   = norm_q ? pmin_q & LOW : pmin_q;
    assign b.min_addr = paddr_q;
    assign b.rd_vld   = rv_q;
    assign b.rd_pm    = rpm_q;
    assign b.rd_dec   = rdec_q;
    assign b.step_err = err_q;
endmodule

// File: tb/tb_pm_bank_mem.sv
// tb_pm_bank_mem: directed vector table plus randomized steps against a step-level reference model
module tb_pm_bank_mem;
    localparam int PM_W = 7, ADDR_W = 2, ID_W = 3, NS = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic we, wd, wl, re, rel;
    logic [1:0] wa, ra;
    logic [6:0] wp;
    logic [2:0] wi;
    int n_chk = 0, n_fail = 0;

    pm_bank_if #(.PM_W(PM_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) ia ();
    pm_bank_if #(.PM_W(PM_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) ib ();

    assign ia.wr_en = we;  assign ia.wr_addr = wa; assign ia.wr_pm = wp;  assign ia.wr_dec = wd;
    assign ia.wr_id = wi;  assign ia.wr_last = wl; assign ia.rd_en = re;  assign ia.rd_addr = ra;
    assign ia.rd_release = rel;
    assign ib.wr_en = we;  assign ib.wr_addr = wa; assign ib.wr_pm = wp;  assign ib.wr_dec = wd;
    assign ib.wr_id = wi;  assign ib.wr_last = wl; assign ib.rd_en = re;  assign ib.rd_addr = ra;
    assign ib.rd_release = rel;

    pm_bank_mem #(.PM_W(PM_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .NORM_EN(1'b1)) dut_a (
        .PM_clk(clk), .PM_rst(rst), .b(ia.slave));
    pm_bank_mem #(.PM_W(PM_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .NORM_EN(1'b0)) dut_b (
        .PM_clk(clk), .PM_rst(rst), .b(ib.slave));

    always #5 clk = ~clk;

    // reference model: two banks, a per-step write log and per-state write counts
    bit [7:0]  bank [2][NS];
    int        cur;
    int        cnt [NS];
    bit [8:0]  wq [$];
    bit        m_rdy, m_norm, m_err, m_rv, m_rdec, m_rnorm;
    bit [2:0]  m_id;
    bit [6:0]  m_min, m_rraw;
    bit [1:0]  m_ma;

    typedef struct {
        bit we; int wa, wp; bit wd, wl; int wi; bit re; int ra; bit rel;
        bit xwr, xrdy; int xid, xmin, xma; bit xerr, xrv; int xrp; bit xrd; int xminb, xrpb;
    } vec_t;
    vec_t tv [21];

    function automatic vec_t v(bit e, int a, int p, bit d, bit l, int i, bit r, int rad, bit rl,
                               bit xwr, bit xrdy, int xid, int xmin, int xma, bit xerr,
                               bit xrv, int xrp, bit xrd, int xminb, int xrpb);
        vec_t t;
        t.we = e; t.wa = a; t.wp = p; t.wd = d; t.wl = l; t.wi = i; t.re = r; t.ra = rad; t.rel = rl;
        t.xwr = xwr; t.xrdy = xrdy; t.xid = xid; t.xmin = xmin; t.xma = xma; t.xerr = xerr;
        t.xrv = xrv; t.xrp = xrp; t.xrd = xrd; t.xminb = xminb; t.xrpb = xrpb;
        return t;
    endfunction

    function automatic bit [6:0] nz(bit [6:0] val, bit n);
        return n ? 7'(val - 7'd64) : val;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic set(bit e, int a, int p, bit d, bit l, int i, bit r, int rad, bit rl);
        we = e; wa = 2'(a); wp = 7'(p); wd = d; wl = l; wi = 3'(i); re = r; ra = 2'(rad); rel = rl;
    endtask

    task automatic model_reset();
        m_rdy = 0; m_norm = 0; m_err = 0; m_rv = 0; m_rdec = 0; m_rnorm = 0;
        m_id = 0; m_min = 0; m_rraw = 0; m_ma = 0; cur = 0;
        wq.delete();
        cnt = '{default: 0};
    endtask

    task automatic model_check();
        chk("out_norm", {ia.step_rdy, ia.step_id, ia.min_pm, ia.min_addr, ia.step_err, ia.rd_vld, ia.rd_pm, ia.rd_dec},
            {m_rdy, m_id, nz(m_min, m_norm), m_ma, m_err, m_rv, nz(m_rraw, m_rnorm), m_rdec});
        chk("out_raw", {ib.step_rdy, ib.step_id, ib.min_pm, ib.min_addr, ib.step_err, ib.rd_vld, ib.rd_pm, ib.rd_dec},
            {m_rdy, m_id, m_min, m_ma, m_err, m_rv, m_rraw, m_rdec});
    endtask

    task automatic cycle();
        bit acc, com, bad;
        int pb;
        bit [8:0] best;
        #1;
        chk("wr_ready", {ia.wr_ready, ib.wr_ready}, {2{!m_rdy || rel}});
        acc = we && (!m_rdy || rel);
        com = acc && wl;
        pb = 1 - cur;
        @(posedge clk);
        #1;
        m_rv = re && m_rdy;
        if (m_rv) begin
            m_rraw = bank[pb][ra][7:1];
            m_rdec = bank[pb][ra][0];
            m_rnorm = m_norm;
        end
        if (acc) begin
            bank[cur][wa] = {wp, wd};
            cnt[wa]++;
            wq.push_back({wa, wp});
        end
        m_err = 0;
        if (com) begin
            best = wq[0];
            foreach (wq[i]) if ({wq[i][6:0], wq[i][8:7]} < {best[6:0], best[8:7]}) best = wq[i];
            bad = 0;
            for (int a = 0; a < NS; a++) if (cnt[a] != 1) bad = 1;
            m_err = bad; m_rdy = 1; m_id = wi; m_min = best[6:0]; m_ma = best[8:7]; m_norm = best[6];
            cur = 1 - cur;
            wq.delete();
            cnt = '{default: 0};
        end else if (rel && m_rdy) m_rdy = 0;
        model_check();
    endtask

    initial begin
        //          we a  pm  d l id re ra rl  xwr rdy id min ma err rv rp  rd minb rpb
        tv[0]  = v(1, 0, 9,   1, 0, 0, 0, 0, 0,  1,  0, 0, 0,  0, 0,  0, 0,  0, 0,  0);
        tv[1]  = v(1, 1, 4,   0, 0, 0, 0, 0, 0,  1,  0, 0, 0,  0, 0,  0, 0,  0, 0,  0);
        tv[2]  = v(1, 2, 7,   1, 0, 0, 0, 0, 0,  1,  0, 0, 0,  0, 0,  0, 0,  0, 0,  0);
        tv[3]  = v(1, 3, 4,   1, 1, 5, 0, 0, 0,  1,  1, 5, 4,  1, 0,  0, 0,  0, 4,  0);
        tv[4]  = v(0, 0, 0,   0, 0, 0, 1, 2, 0,  0,  1, 5, 4,  1, 0,  1, 7,  1, 4,  7);
        tv[5]  = v(1, 0, 70,  0, 0, 0, 0, 0, 1,  1,  0, 5, 4,  1, 0,  0, 7,  1, 4,  7);
        tv[6]  = v(1, 1, 66,  1, 0, 0, 0, 0, 0,  1,  0, 5, 4,  1, 0,  0, 7,  1, 4,  7);
        tv[7]  = v(1, 2, 80,  0, 0, 0, 0, 0, 0,  1,  0, 5, 4,  1, 0,  0, 7,  1, 4,  7);
        tv[8]  = v(1, 3, 127, 1, 1, 2, 0, 0, 0,  1,  1, 2, 2,  1, 0,  0, 7,  1, 66, 7);
        tv[9]  = v(0, 0, 0,   0, 0, 0, 1, 3, 0,  0,  1, 2, 2,  1, 0,  1, 63, 1, 66, 127);
        tv[10] = v(1, 0, 20,  0, 1, 6, 0, 0, 0,  0,  1, 2, 2,  1, 0,  0, 63, 1, 66, 127);
        tv[11] = v(0, 0, 0,   0, 0, 0, 1, 1, 0,  0,  1, 2, 2,  1, 0,  1, 2,  1, 66, 66);
        tv[12] = v(1, 0, 20,  0, 1, 6, 0, 0, 1,  1,  1, 6, 20, 0, 1,  0, 2,  1, 20, 66);
        tv[13] = v(0, 0, 0,   0, 0, 0, 0, 0, 1,  1,  0, 6, 20, 0, 0,  0, 2,  1, 20, 66);
        tv[14] = v(1, 0, 5,   0, 0, 0, 0, 0, 0,  1,  0, 6, 20, 0, 0,  0, 2,  1, 20, 66);
        tv[15] = v(1, 1, 8,   1, 0, 0, 0, 0, 0,  1,  0, 6, 20, 0, 0,  0, 2,  1, 20, 66);
        tv[16] = v(1, 1, 3,   0, 0, 0, 0, 0, 0,  1,  0, 6, 20, 0, 0,  0, 2,  1, 20, 66);
        tv[17] = v(1, 3, 9,   1, 1, 3, 0, 0, 0,  1,  1, 3, 3,  1, 1,  0, 2,  1, 3,  66);
        tv[18] = v(0, 0, 0,   0, 0, 0, 1, 1, 0,  0,  1, 3, 3,  1, 0,  1, 3,  0, 3,  3);
        tv[19] = v(1, 2, 50,  1, 1, 4, 1, 1, 1,  1,  1, 4, 50, 2, 1,  1, 3,  0, 50, 3);
        tv[20] = v(0, 0, 0,   0, 0, 0, 1, 2, 0,  0,  1, 4, 50, 2, 0,  1, 50, 1, 50, 50);

        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ia.wr_ready, 1'b1);
        model_check();
        @(negedge clk) rst = 1'b0;

        for (int k = 0; k < 21; k++) begin
            set(tv[k].we, tv[k].wa, tv[k].wp, tv[k].wd, tv[k].wl, tv[k].wi, tv[k].re, tv[k].ra, tv[k].rel);
            #1;
            chk($sformatf("tv%0d_wr_ready", k), ia.wr_ready, tv[k].xwr);
            cycle();
            chk($sformatf("tv%0d_out", k),
                {ia.step_rdy, ia.step_id, ia.min_pm, ia.min_addr, ia.step_err, ia.rd_vld, ia.rd_pm, ia.rd_dec},
                {tv[k].xrdy, 3'(tv[k].xid), 7'(tv[k].xmin), 2'(tv[k].xma), tv[k].xerr, tv[k].xrv,
                 7'(tv[k].xrp), tv[k].xrd});
            chk($sformatf("tv%0d_raw", k), {ib.min_pm, ib.rd_pm}, {7'(tv[k].xminb), 7'(tv[k].xrpb)});
        end

        // reset in the middle of a step discards it without an error pulse
        set(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
        set(1, 0, 33, 1, 0, 0, 0, 0, 0); cycle();
        set(1, 1, 44, 0, 0, 0, 0, 0, 0); cycle();
        #2 rst = 1'b1;
        #1;
        chk("midreset_out", {ia.step_rdy, ia.step_id, ia.min_pm, ia.min_addr, ia.step_err, ia.rd_vld, ia.rd_pm, ia.rd_dec}, 0);
        chk("midreset_ready", ia.wr_ready, 1'b1);
        model_reset();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int a = 0; a < NS; a++) begin
            set(1, a, 10 + a, a % 2, a == NS - 1, 7, 0, 0, 0);
            cycle();
        end
        chk("fresh_step", {ia.step_rdy, ia.step_id, ia.min_pm, ia.min_addr, ia.step_err}, {1'b1, 3'd7, 7'd10, 2'd0, 1'b0});

        for (int s = 0; s < 150; s++) begin
            int ord [5];
            int n, base, t, j;
            if ($urandom_range(0, 2) == 0) begin
                set(1, $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3), 0);
                cycle();
            end
            repeat ($urandom_range(0, 2)) begin
                set(0, 0, 0, 0, 0, 0, 1, $urandom_range(0, 3), 0);
                cycle();
            end
            for (int i = 0; i < NS; i++) ord[i] = i;
            for (int i = NS - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            n = NS;
            if ($urandom_range(0, 3) == 0) begin
                ord[NS] = ord[$urandom_range(0, NS - 1)];
                n = NS + 1;
            end
            base = $urandom_range(0, 1) ? $urandom_range(64, 110) : 0;
            for (int i = 0; i < n; i++) begin
                set(1, ord[i], $urandom_range(base, 127), $urandom_range(0, 1), i == n - 1, $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 3), i == 0);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
